apb_regfile_bridge: RTL

//  APB3 slave stage directly upstream of the 8x8 register file. Decodes APB reads/writes and

---
 rtl/apb_regfile_bridge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_regfile_bridge.sv
// APB3 slave front-end for the 8x8 register file: decodes APB transfers, drives the
// regfile APB write path and read port 2, and stalls APB writes while the core owns the write port.
module apb_regfile_bridge #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned APB_REG  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       core_wr_en,
    input  logic [2:0] core_wr_addr,
    input  logic [7:0] core_wr_data,
    output logic       reg_write_en,
    output logic [2:0] reg_write_addr,
    output logic [7:0] reg_write_data,
    output logic       apb_op,
    output logic [7:0] apb_data,
    output logic [2:0] reg2_read_addr,
    input  logic [7:0] reg2_read_data
);

    localparam int unsigned WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 2);

    typedef enum logic [1:0] {
        IDLE,
        RD_CAP,
        WR_WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [7:0]     pwdata_q;
    logic [7:0]     apb_data_q;
    logic [WCW-1:0] wait_cnt;
    logic           setup;
    logic           dec_err;

    assign setup   = PSEL && !PENABLE;
    assign dec_err = (PADDR[1:0] != 2'b00) || (PWRITE && (PADDR[4:2] != 3'(APB_REG)));

    // Commit is decoded in the same cycle the core port is seen idle, so the strobe can
    // never coincide with a core write; apb_data presents the latched word during commit.
    assign apb_op         = (state == WR_WAIT) && PSEL && !core_wr_en;
    assign apb_data       = apb_op ? pwdata_q : apb_data_q;
    assign reg_write_en   = core_wr_en | apb_op;
    assign reg_write_addr = core_wr_addr;
    assign reg_write_data = core_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            PRDATA         <= '0;
            PREADY         <= 1'b0;
            PSLVERR        <= 1'b0;
            reg2_read_addr <= '0;
            pwdata_q       <= '0;
            apb_data_q     <= '0;
            wait_cnt       <= '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup) begin
                        reg2_read_addr <= PADDR[4:2];
                        pwdata_q       <= PWDATA;
                        wait_cnt       <= '0;
                        if (dec_err) begin
                            state   <= RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end else if (PWRITE) begin
                            state <= WR_WAIT;
                        end else begin
                            state <= RD_CAP;
                        end
                    end
                end
                RD_CAP: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else begin
                        PRDATA <= reg2_read_data;
                        PREADY <= 1'b1;
                        state  <= RESP;
                    end
                end
                WR_WAIT: begin
                    if (!PSEL) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (!core_wr_en) begin
                        apb_data_q <= pwdata_q;
                        PREADY     <= 1'b1;
                        state      <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
